frame_sequencer: RTL and testbench
==================================

// Module: frame_sequencer
// PURPOSE
//  Upstream feeder for the LED-array serial byte writer. Holds a 16-byte
//  framebuffer and, on each refresh request, issues one complete display
//  frame to the writer, one byte at a time, over a valid/busy handshake.
//  Frame order: data cmd, address cmd, NUM_DIGITS data bytes, display ctrl.
// PARAMETERS
//  NUM_DIGITS     16    framebuffer depth (bytes per frame), 1..16
//  CMD_DATA       8'h40 data command, auto-increment address mode
//  CMD_ADDR       8'hC0 address command, start at digit 0
//  CMD_DISP_BASE  8'h80 display control base; OR'd with {on,bri[2:0]}
// PORTS
//  clk           in   1  system clock; same clock as the byte writer
//  rst_n         in   1  asynchronous reset, active low
//  start         in   1  refresh request; 1-cycle pulse or level
//  brightness    in   3  PWM level, sampled at frame start
//  display_on    in   1  display enable, sampled at frame start
//  fb_wr_en      in   1  framebuffer write strobe
//  fb_wr_addr    in   4  framebuffer write address (digit index)
//  fb_wr_data    in   8  framebuffer write data (segment pattern)
//  tx_busy       in   1  busy from the byte writer
//  tx_valid      out  1  1-cycle pulse: tx_value is offered to the writer
//  tx_value      out  8  byte to send; held until the next byte is issued
//  frame_busy    out  1  high from frame accept until frame_done
//  frame_done    out  1  1-cycle pulse after the last byte completes
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; tx_valid=0, tx_value=8'h00,
//   frame_busy=0, frame_done=0; pending=0; all framebuffer bytes=8'h00.
//  Framebuffer: sync write on fb_wr_en at any time, including mid-frame.
//   A data byte is read when it is issued, so a write lands in the current
//   frame only if it is ahead of the read pointer. Writes with
//   addr>=NUM_DIGITS are ignored.
//  start seen in IDLE: latch {display_on,brightness} into ctrl_q, set
//   frame_busy, go to ISSUE with byte index idx=0.
//  start seen while frame_busy: set pending (one deep; extras merge).
//  Byte index: idx=0 gives CMD_DATA; idx=1 gives CMD_ADDR;
//   idx=2..NUM_DIGITS+1 gives fb[idx-2];
//   idx=NUM_DIGITS+2 gives CMD_DISP_BASE|{ctrl_q[3],ctrl_q[2:0]}.
//   idx is 5 bits wide; last index is NUM_DIGITS+2 (18 by default).
//  FSM states:
//   IDLE     wait for start or pending.
//   ISSUE    load tx_value with byte(idx), pulse tx_valid for 1 cycle,
//            go to WAIT_HI.
//   WAIT_HI  wait for tx_busy=1. The writer runs a divided clock, so busy
//            rises many clk cycles after valid. Wait here with no
//            timeout; do not re-pulse tx_valid.
//   WAIT_LO  wait for tx_busy=0. Then, if idx is the last index, go to
//            DONE; otherwise increment idx and go to ISSUE.
//   DONE     pulse frame_done for 1 cycle, clear frame_busy. If pending,
//            clear pending, resample ctrl_q, set frame_busy again and go
//            to ISSUE with idx=0. Otherwise go to IDLE.
//  Never more than one byte is outstanding: tx_valid pulses only in
//   ISSUE, so there is at least one full busy high/low cycle between
//   pulses.
//  If tx_busy is already high on entry to ISSUE, WAIT_HI passes at once
//   and WAIT_LO waits for the busy fall.
//  If start and DONE coincide, the start counts as pending, which yields
//   back-to-back frames.
//  Reset mid-frame aborts at once. No frame_done is issued. The writer may
//   finish its current byte on its own.
//  Latency: start to first tx_valid is 2 clk. DONE to next frame's first
//   tx_valid is 2 clk.
// TESTING
//  1. Reset, then check outputs: tx_valid=0, tx_value=00, frame_busy=0,
//     frame_done=0. Read out a frame and check all data bytes=00.
//  2. Set fb[i]=i, bri=7, on=1, pulse start. The writer model must receive
//     40,C0,00..0F,8F (19 bytes), then one frame_done pulse.
//  3. Set on=0, bri=3, pulse start. The last byte must be 83. Change bri
//     mid-frame: the last byte stays 83.
//  4. Writer model holds busy high for 50 cycles per byte. Require exactly
//     one tx_valid per busy cycle and no tx_valid while busy=1.
//  5. Pulse start 3x during a frame. Require exactly one extra frame,
//     starting 2 clk after frame_done.
//  6. Assert rst_n low during the data byte with idx=7. Outputs reset at
//     once, FSM returns to IDLE, and the next start sends a full 19-byte
//     frame.

Source files
------------

// File: rtl/frame_sequencer.sv
// Feeds one display frame per refresh request to the serial byte writer:
// data cmd, address cmd, NUM_DIGITS framebuffer bytes, display control.
module frame_sequencer #(
  parameter int          NUM_DIGITS    = 16,
  parameter logic [7:0]  CMD_DATA      = 8'h40,
  parameter logic [7:0]  CMD_ADDR      = 8'hC0,
  parameter logic [7:0]  CMD_DISP_BASE = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] brightness,
  input  logic       display_on,
  input  logic       fb_wr_en,
  input  logic [3:0] fb_wr_addr,
  input  logic [7:0] fb_wr_data,
  input  logic       tx_busy,
  output logic       tx_valid,
  output logic [7:0] tx_value,
  output logic       frame_busy,
  output logic       frame_done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_DIGITS + 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic       pending_q, pending_d;
  logic       busy_q, busy_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_value_q, tx_value_d;
  logic [7:0] fb_q [NUM_DIGITS];
  logic [7:0] fb_d [NUM_DIGITS];
  logic [7:0] byte_sel;

  // Out-of-range addresses simply match no entry.
  always_comb begin
    fb_d = fb_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (fb_wr_en && fb_wr_addr == 4'(i)) fb_d[i] = fb_wr_data;
  end

  always_comb begin
    byte_sel = 8'h00;
    if (idx_q == 5'd0)
      byte_sel = CMD_DATA;
    else if (idx_q == 5'd1)
      byte_sel = CMD_ADDR;
    else if (idx_q == LAST_IDX)
      byte_sel = CMD_DISP_BASE | {4'h0, ctrl_q};
    else
      for (int i = 0; i < NUM_DIGITS; i++)
        if (idx_q == 5'(i + 2)) byte_sel = fb_q[i];
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ctrl_d     = ctrl_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    tx_valid_d = 1'b0;
    tx_value_d = tx_value_q;
    if (start && busy_q) pending_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start || pending_q) begin
          ctrl_d    = {display_on, brightness};
          busy_d    = 1'b1;
          idx_d     = 5'd0;
          pending_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tx_value_d = byte_sel;
        tx_valid_d = 1'b1;
        state_d    = WAIT_HI;
      end
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        // A start arriving this cycle is treated like a pending request.
        busy_d    = 1'b0;
        pending_d = 1'b0;
        state_d   = IDLE;
        if (pending_q || start) begin
          ctrl_d  = {display_on, brightness};
          busy_d  = 1'b1;
          idx_d   = 5'd0;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 5'd0;
      ctrl_q     <= 4'h0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_value_q <= 8'h00;
      for (int i = 0; i < NUM_DIGITS; i++) fb_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      tx_valid_q <= tx_valid_d;
      tx_value_q <= tx_value_d;
      fb_q       <= fb_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_value   = tx_value_q;
  assign frame_busy = busy_q;
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: a writer model consumes bytes, a
// monitor compares every issued byte and frame_done against a frame model.
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] brightness = 3'd0;
  logic       display_on = 1'b0;
  logic       fb_wr_en = 1'b0;
  logic [3:0] fb_wr_addr = 4'd0;
  logic [7:0] fb_wr_data = 8'd0;
  logic       tx_busy = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_value;
  logic       frame_busy;
  logic       frame_done;

  frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .brightness(brightness),
    .display_on(display_on), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .tx_busy(tx_busy), .tx_valid(tx_valid),
    .tx_value(tx_value), .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         nbytes = 0;
  int         hold_cyc = 3;
  bit         outstanding = 1'b0;
  logic [8:0] expq[$];
  logic [7:0] fb_m[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Byte writer model: busy rises some cycles after valid, holds, then falls.
  initial forever begin
    @(negedge clk);
    if (tx_valid) begin
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat (hold_cyc) @(posedge clk);
      #1 tx_busy = 1'b0;
      outstanding = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every byte and every frame_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid) begin
        chk("valid_while_busy", int'(tx_busy), 0);
        chk("one_valid_per_busy", int'(outstanding), 0);
        outstanding = 1'b1;
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL byte_unexpected: got %02h want none", tx_value);
        end else chk("byte", int'({1'b0, tx_value}), int'(expq.pop_front()));
        nbytes++;
      end
      if (frame_done) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got frame_done want none");
        end else chk("frame_done", 9'h100, int'(expq.pop_front()));
        nbytes = 0;
      end
    end
  end

  task automatic push_frame(input logic on, input logic [2:0] bri);
    expq.push_back(9'h040);
    expq.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) expq.push_back({1'b0, fb_m[i]});
    expq.push_back({1'b0, 8'h80 | {4'h0, on, bri}});
    expq.push_back(9'h100);
  endtask

  task automatic fb_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    fb_wr_en = 1'b1; fb_wr_addr = a; fb_wr_data = d;
    @(negedge clk);
    fb_wr_en = 1'b0;
    fb_m[a] = d;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_frame(input logic on, input logic [2:0] bri);
    int t0;
    display_on = on; brightness = bri;
    push_frame(on, bri);
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 8 && !tx_valid; k++) @(negedge clk);
    chk("start_latency", cyc - t0, 2);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (expq.size() == 0 && !frame_busy && !tx_busy) break;
    end
    if (k == 5000) begin
      total++; bad++;
      $display("FAIL idle_timeout: got %0d pending entries want 0", expq.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, int'(tx_valid), 0);
    chk({tag, "_tx_value"}, int'(tx_value), 0);
    chk({tag, "_frame_busy"}, int'(frame_busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    int td;
    int k;
    for (int i = 0; i < 16; i++) fb_m[i] = 8'h00;

    // Reset state, then a frame of an untouched framebuffer.
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_rst");
    run_frame(1'b1, 3'd7);
    wait_idle();

    // Counting pattern, full brightness.
    for (int i = 0; i < 16; i++) fb_write(4'(i), 8'(i));
    run_frame(1'b1, 3'd7);
    wait_idle();

    // Control is latched at frame start; later changes do not leak in.
    run_frame(1'b0, 3'd3);
    repeat (30) @(negedge clk);
    brightness = 3'd5;
    display_on = 1'b1;
    wait_idle();

    // Slow writer.
    hold_cyc = 50;
    run_frame(1'b1, 3'd1);
    wait_idle();
    hold_cyc = 3;

    // Three starts mid-frame collapse into a single follow-on frame.
    run_frame(1'b1, 3'd5);
    repeat (10) @(negedge clk);
    push_frame(1'b1, 3'd5);
    pulse_start(); pulse_start(); pulse_start();
    for (k = 0; k < 3000 && !frame_done; k++) @(negedge clk);
    td = cyc;
    @(negedge clk);
    for (int j = 0; j < 8 && !tx_valid; j++) @(negedge clk);
    chk("done_to_next_valid", cyc - td, 2);
    wait_idle();
    repeat (60) @(negedge clk);
    chk("no_third_frame_busy", int'(frame_busy), 0);
    chk("no_third_frame_queue", expq.size(), 0);

    // Random framebuffer contents and control settings.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 8; w++)
        fb_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      run_frame(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      wait_idle();
    end

    // Reset while the idx=7 byte is in flight.
    run_frame(1'b1, 3'd6);
    for (k = 0; k < 2000; k++) begin
      @(posedge clk); #2;
      if (nbytes == 8) break;
    end
    chk("reached_idx7", nbytes, 8);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midframe_rst");
    expq.delete();
    nbytes = 0;
    for (int i = 0; i < 16; i++) fb_m[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (k = 0; k < 200 && tx_busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    run_frame(1'b1, 3'd2);
    wait_idle();
    chk("final_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
